// File: rtl/data_mem_responder_if.sv
// Load/store request and response channel between the pipeline (master)
// and the data-memory responder (slave).
interface data_mem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/data_mem_responder.sv
// Data-memory responder: byte/half/word loads and stores on a synchronous
// word-wide RAM, one-entry response register, error reporting for the trap logic.
module data_mem_responder #(
   parameter int          DEPTH     = 256,
   parameter logic [31:0] BASE_ADDR = 32'h400
) (
   input logic                 clk,
   input logic                 reset,
   data_mem_responder_if.slave mem
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [3:0] OP_NONE = 4'd0;
   localparam logic [3:0] OP_LB   = 4'd1;
   localparam logic [3:0] OP_LH   = 4'd2;
   localparam logic [3:0] OP_LW   = 4'd3;
   localparam logic [3:0] OP_LBU  = 4'd4;
   localparam logic [3:0] OP_LHU  = 4'd5;
   localparam logic [3:0] OP_SB   = 4'd6;
   localparam logic [3:0] OP_SH   = 4'd7;
   localparam logic [3:0] OP_SW   = 4'd8;

   typedef enum logic {S_EMPTY, S_FULL} state_t;

   state_t        r_state, w_state_nxt;
   logic          w_rsp_valid;
   logic          w_req_ready;
   logic          w_accept;

   logic          w_is_load, w_is_store, w_is_half, w_is_word;
   logic          w_bad_op, w_misalign, w_oor, w_err;
   logic [32:0]   w_lo, w_hi, w_addr33;
   logic [AW+1:0] w_off;
   logic [AW-1:0] w_idx;
   logic [1:0]    w_lane;
   logic [3:0]    w_be;
   logic [31:0]   w_wdata;
   logic          w_wr_en;

   logic [31:0]   r_mem [DEPTH];
   logic [31:0]   r_rd_word;
   logic [3:0]    r_op;
   logic [1:0]    r_lane;
   logic          r_err;
   logic          r_load;

   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [31:0]   w_rdata;

   // ---------------- handshake / FSM ----------------
   assign w_rsp_valid = (r_state == S_FULL);
   assign w_req_ready = !reset && (!w_rsp_valid || mem.rsp_ready);
   assign w_accept    = mem.req_valid && w_req_ready;

   always_ff @(posedge clk) begin
      if (reset) r_state <= S_EMPTY;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_EMPTY: if (w_accept) w_state_nxt = S_FULL;
         S_FULL:  if (mem.rsp_ready && !w_accept) w_state_nxt = S_EMPTY;
         default: w_state_nxt = S_EMPTY;
      endcase
   end

   // ---------------- request decode ----------------
   assign w_is_load  = (mem.req_op == OP_LB)  || (mem.req_op == OP_LH) ||
                       (mem.req_op == OP_LW)  || (mem.req_op == OP_LBU) ||
                       (mem.req_op == OP_LHU);
   assign w_is_store = (mem.req_op == OP_SB)  || (mem.req_op == OP_SH) ||
                       (mem.req_op == OP_SW);
   assign w_is_half  = (mem.req_op == OP_LH)  || (mem.req_op == OP_LHU) ||
                       (mem.req_op == OP_SH);
   assign w_is_word  = (mem.req_op == OP_LW)  || (mem.req_op == OP_SW);

   assign w_bad_op   = !(w_is_load || w_is_store);
   assign w_misalign = (w_is_half && mem.req_addr[0]) ||
                       (w_is_word && (mem.req_addr[1:0] != 2'b00));

   // 33-bit bounds so BASE_ADDR+4*DEPTH cannot wrap past 2^32
   assign w_addr33   = {1'b0, mem.req_addr};
   assign w_lo       = {1'b0, BASE_ADDR};
   assign w_hi       = w_lo + 33'(4 * DEPTH);
   assign w_oor      = (w_addr33 < w_lo) || (w_addr33 >= w_hi);
   assign w_err      = w_bad_op || w_misalign || w_oor;

   // Only the low bits of the offset matter once the range check has passed
   assign w_off      = mem.req_addr[AW+1:0] - BASE_ADDR[AW+1:0];
   assign w_idx      = w_off[AW+1:2];
   assign w_lane     = w_off[1:0];

   always_comb begin
      w_be    = 4'b0000;
      w_wdata = mem.req_wdata;
      case (mem.req_op)
         OP_SW: w_be = 4'b1111;
         OP_SH: begin
            w_be    = w_lane[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{mem.req_wdata[15:0]}};
         end
         OP_SB: begin
            w_be    = 4'b0001 << w_lane;
            w_wdata = {4{mem.req_wdata[7:0]}};
         end
         default: w_be = 4'b0000;
      endcase
   end

   assign w_wr_en = w_accept && w_is_store && !w_err;

   // ---------------- RAM ----------------
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
      if (w_accept) r_rd_word <= r_mem[w_idx];
   end

   // Side info captured with the read word; only changes on a new accept
   always_ff @(posedge clk) begin
      if (reset) begin
         r_op   <= OP_NONE;
         r_lane <= 2'b00;
         r_err  <= 1'b0;
         r_load <= 1'b0;
      end else if (w_accept) begin
         r_op   <= mem.req_op;
         r_lane <= w_lane;
         r_err  <= w_err;
         r_load <= w_is_load && !w_err;
      end
   end

   // ---------------- lane select / extension ----------------
   always_comb begin
      w_byte  = r_rd_word[{r_lane, 3'b000} +: 8];
      w_half  = r_lane[1] ? r_rd_word[31:16] : r_rd_word[15:0];
      w_rdata = 32'h0;
      if (w_rsp_valid && r_load) begin
         case (r_op)
            OP_LW:   w_rdata = r_rd_word;
            OP_LH:   w_rdata = {{16{w_half[15]}}, w_half};
            OP_LHU:  w_rdata = {16'h0, w_half};
            OP_LB:   w_rdata = {{24{w_byte[7]}}, w_byte};
            OP_LBU:  w_rdata = {24'h0, w_byte};
            default: w_rdata = 32'h0;
         endcase
      end
   end

   assign mem.req_ready = w_req_ready;
   assign mem.rsp_valid = w_rsp_valid;
   assign mem.rsp_rdata = w_rdata;
   assign mem.rsp_error = w_rsp_valid && r_err;

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
Data-memory responder at the memory end of the pipeline's load/store interface. It accepts one mem_op_t request per handshake and performs word, half or byte accesses on an internal synchronous word-wide RAM. Loads are sign- or zero-extended; stores use byte lanes. Misaligned, out-of-range and invalid requests are reported as errors, which the trap logic consumes.

Parameters:
DEPTH, 256, number of 32-bit words in the RAM (power of two, at least 4).
BASE_ADDR, 32'h400, byte address of word 0 (equals DATA_ADDR).

Ports:
clk  in  1  clock, all logic on the rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  responder can accept a request this cycle
req_op  in  4  mem_op_t operation
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0])
rsp_valid  out  1  response present
rsp_ready  in  1  consumer takes the response this cycle
rsp_rdata  out  32  extended load data; 0 for stores and errors
rsp_error  out  1  request faulted; no memory side effect occurred

Behaviour:
- Interface: one clock, clk; synchronous active-high reset, reset.
- Accept happens when req_valid && req_ready.
- req_ready = !reset && (!rsp_valid || rsp_ready). This allows back-to-back accepts while the consumer drains.
- States:
  - EMPTY: no response is held.
  - FULL: a response is held.
- Transitions:
  - EMPTY to FULL on accept.
  - FULL to EMPTY on rsp_ready when there is no accept.
  - FULL stays FULL on rsp_ready with an accept (the new response replaces the old one).
  - FULL stays FULL when rsp_ready is low; rsp_rdata and rsp_error must hold stable.
- Latency: a request accepted at edge N has rsp_valid high in the cycle after edge N. Throughput is one per cycle.
- Reset values: state EMPTY, rsp_valid=0, rsp_rdata=0, rsp_error=0, req_ready=0 while reset is high. RAM contents are not reset.
- Reset mid-operation: a held response is discarded. A store accepted in the same cycle that reset is high is not accepted, because req_ready=0.
- Error checks, in priority order. Any error gives rsp_error=1 and rsp_rdata=0, with no RAM write:
  - req_op is LOAD_STORE_NONE or an unencoded value (9..15).
  - Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]!=0.
  - Out of range: addr < BASE_ADDR or addr >= BASE_ADDR+4*DEPTH. Use 33-bit compare; no wrap-around at 2^32.
- Word index = (addr-BASE_ADDR)[log2(DEPTH)+1:2].
- Stores are written at the accept edge:
  - SW: all lanes.
  - SH: lanes {addr[1]*2, +1} get wdata[15:0].
  - SB: lane addr[1:0] gets wdata[7:0].
  - Other lanes are unchanged. The response is rsp_error=0, rsp_rdata=0.
- Loads:
  - RAM is read at the accept edge. Register op and addr[1:0] alongside.
  - Lane select and extension act on the registered word. This may be combinational after the RAM register or registered, provided the latency above holds.
  - LW: the whole word.
  - LH/LHU: half at addr[1]; sign- or zero-extended.
  - LB/LBU: byte at addr[1:0]; sign- or zero-extended.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data.
- Held response: the registered read word and its side info must not change while FULL and not drained.

Test Plan:
- Word round trip: SW addr 0x400 data 0xDEADBEEF, then LW 0x400 -> rsp_rdata=0xDEADBEEF, rsp_error=0, each response one cycle after accept.
- Byte/half extension: after the word above, LB 0x403 -> 0xFFFFFFDE; LBU 0x403 -> 0x000000DE; LH 0x400 -> 0xFFFFBEEF; LHU 0x402 -> 0x0000DEAD.
- Lane stores: SB 0x401 data 0x12 then LW 0x400 -> 0xDEAD12EF; SH 0x402 data 0x5678 then LW 0x400 -> 0x567812EF.
- Errors:
  - LW 0x402 -> rsp_error=1, rdata=0.
  - SH 0x401 -> rsp_error=1, and a later LW 0x400 is unchanged.
  - LW 0x3FC -> error.
  - LW 0x400+4*DEPTH -> error.
  - LW 0xFFFFFFFC -> error.
  - op=LOAD_STORE_NONE -> error.
- Backpressure: hold rsp_ready=0 for 3 cycles after LW 0x400 -> req_ready=0, rsp_valid and data stable. Then rsp_ready=1 with a new request valid -> it is accepted in the same cycle, and its response follows next cycle.
- Reset: assert reset while FULL -> next cycle rsp_valid=0, req_ready=0; after release, the previously stored word still reads back.
